// File: rtl/joy_md_pkg.sv
// rtl/joy_md_pkg.sv - shared constants and types for the Mega Drive pad responder
package joy_md_pkg;

  // Bit positions in the buttons vector (MS ZYXCBAUDLR, bit 0 = Right)
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  // Select phase counter, wraps every four rising select edges
  typedef logic [1:0] md_phase_t;

  // 1.5 ms idle window at 48 MHz
  localparam int MD_TIMEOUT_DEFAULT = 72000;

  // Positions of the pad pins inside joy_out
  localparam int PIN1 = 0;
  localparam int PIN2 = 1;
  localparam int PIN3 = 2;
  localparam int PIN4 = 3;
  localparam int PIN6 = 4;
  localparam int PIN9 = 5;

endpackage

// File: rtl/md_sel_sync.sv
// rtl/md_sel_sync.sv - select line synchronizer with optional glitch filter (JOY_MD6_SEL_FILTER_EN)
module md_sel_sync (
  input  logic clk,
  input  logic reset,
  input  logic sel_async,
  output logic sel_level,
  output logic sel_rise,
  output logic sel_fall
);

  logic [1:0] sync_q;
  logic       level_q;

  // Two-flop synchronizer; idle select is high so both flops reset to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], sel_async};
  end

`ifdef JOY_MD6_SEL_FILTER_EN
  logic [2:0] hist_q;

  // Last three synchronized samples, used to demand four equal samples in a row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 3'b111;
    else       hist_q <= {hist_q[1:0], sync_q[1]};
  end

  // A new level is accepted only once it has been stable for four samples
  always_comb begin
    sel_level = level_q;
    if (hist_q == {3{sync_q[1]}}) sel_level = sync_q[1];
  end
`else
  // Unfiltered: the synchronizer output is the clean level
  always_comb begin
    sel_level = sync_q[1];
  end
`endif

  // Previous clean level for edge strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= sel_level;
  end

  assign sel_rise = sel_level & ~level_q;
  assign sel_fall = ~sel_level & level_q;

endmodule

// File: rtl/joy_md6_responder.sv
// rtl/joy_md6_responder.sv - Mega Drive 3/6-button pad responder; select filter enabled by JOY_MD6_SEL_FILTER_EN
module joy_md6_responder
  import joy_md_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MD_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_sel,
  input  logic [11:0] buttons,
  input  logic        six_btn_en,
  output logic [5:0]  joy_out,
  output logic [1:0]  phase
);

  localparam int               CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             sel_level;
  logic             sel_rise;
  logic             sel_fall;
  logic             sel_edge;
  logic             at_limit;
  md_phase_t        phase_q;
  md_phase_t        phase_next;
  logic [CNT_W-1:0] idle_cnt_q;
  logic [CNT_W-1:0] idle_cnt_next;
  logic [5:0]       pins_raw;

  md_sel_sync u_sel_sync (
    .clk       (clk),
    .reset     (reset),
    .sel_async (joy_sel),
    .sel_level (sel_level),
    .sel_rise  (sel_rise),
    .sel_fall  (sel_fall)
  );

  assign sel_edge = sel_rise | sel_fall;
  assign at_limit = (idle_cnt_q == CNT_LIMIT);
  assign phase    = phase_q;

  // Phase and idle-counter next state; a select edge always beats the timeout
  always_comb begin
    idle_cnt_next = idle_cnt_q;
    phase_next    = phase_q;
    if (sel_edge)      idle_cnt_next = '0;
    else if (!at_limit) idle_cnt_next = idle_cnt_q + CNT_W'(1);

    if (!six_btn_en)              phase_next = '0;
    else if (sel_rise)            phase_next = phase_q + 2'd1;
    else if (at_limit && !sel_edge) phase_next = '0;
  end

  // Pin levels before inversion, chosen from the clean select level and the upcoming phase
  always_comb begin
    pins_raw = '0;
    if (sel_level) begin
      pins_raw[PIN9] = buttons[BTN_C];
      pins_raw[PIN6] = buttons[BTN_B];
      if (phase_next == 2'd3) begin
        pins_raw[PIN4] = buttons[BTN_MODE];
        pins_raw[PIN3] = buttons[BTN_X];
        pins_raw[PIN2] = buttons[BTN_Y];
        pins_raw[PIN1] = buttons[BTN_Z];
      end else begin
        pins_raw[PIN4] = buttons[BTN_R];
        pins_raw[PIN3] = buttons[BTN_L];
        pins_raw[PIN2] = buttons[BTN_D];
        pins_raw[PIN1] = buttons[BTN_U];
      end
    end else begin
      pins_raw[PIN9] = buttons[BTN_START];
      pins_raw[PIN6] = buttons[BTN_A];
      case (phase_next)
        2'd3: begin
          pins_raw[PIN4] = 1'b1;
          pins_raw[PIN3] = 1'b1;
          pins_raw[PIN2] = 1'b1;
          pins_raw[PIN1] = 1'b1;
        end
        2'd2: begin
          pins_raw[PIN4] = 1'b0;
          pins_raw[PIN3] = 1'b0;
          pins_raw[PIN2] = 1'b0;
          pins_raw[PIN1] = 1'b0;
        end
        default: begin
          pins_raw[PIN4] = 1'b0;
          pins_raw[PIN3] = 1'b0;
          pins_raw[PIN2] = buttons[BTN_D];
          pins_raw[PIN1] = buttons[BTN_U];
        end
      endcase
    end
  end

  // State registers and the single registered, active-low pin update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      idle_cnt_q <= '0;
      joy_out    <= 6'b111111;
    end else begin
      phase_q    <= phase_next;
      idle_cnt_q <= idle_cnt_next;
      joy_out    <= ~pins_raw;
    end
  end

endmodule

// File: tb/tb_joy_md6_responder.sv
// tb/tb_joy_md6_responder.sv - randomized self-checking bench for joy_md6_responder
module tb_joy_md6_responder;

  localparam int TO = 200;
`ifdef JOY_MD6_SEL_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 6;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        joy_sel;
  logic        six_btn_en;
  logic [11:0] buttons;
  logic [5:0]  joy_out;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit         hist[$];
  bit         eff_prev;
  int         since;
  int         mp;
  logic [5:0] exp_out;

  joy_md6_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_sel    (joy_sel),
    .buttons    (buttons),
    .six_btn_en (six_btn_en),
    .joy_out    (joy_out),
    .phase      (phase)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Pad pins as seen by the console, from the select level, phase and buttons
  function automatic logic [5:0] pins(input bit s, input int p, input logic [11:0] b);
    logic [5:0] v;
    if (s && p != 3)  v = {b[6], b[5], b[0], b[1], b[2], b[3]};
    else if (s)       v = {b[6], b[5], b[11], b[7], b[8], b[9]};
    else if (p < 2)   v = {b[10], b[4], 2'b00, b[2], b[3]};
    else if (p == 2)  v = {b[10], b[4], 4'b0000};
    else              v = {b[10], b[4], 4'b1111};
    return ~v;
  endfunction

  // Advance the model by one clock using the inputs presented for that clock
  task automatic model_step();
    bit eff;
    bit rise;
    bit edge_s;
    hist.push_front(joy_sel);
    if (hist.size() > 8) void'(hist.pop_back());
    if (reset) begin
      foreach (hist[i]) hist[i] = 1'b1;
      eff_prev = 1'b1;
      since    = 0;
      mp       = 0;
      exp_out  = 6'h3F;
    end else begin
      if (!FILT) eff = hist[2];
      else if (hist[2] == hist[3] && hist[3] == hist[4] && hist[4] == hist[5]) eff = hist[2];
      else eff = eff_prev;
      edge_s = (eff != eff_prev);
      rise   = eff && !eff_prev;
      if (edge_s) since = 0;
      else if (since < TO) since++;
      if (!six_btn_en)     mp = 0;
      else if (rise)       mp = (mp + 1) % 4;
      else if (since >= TO) mp = 0;
      exp_out  = pins(eff, mp, buttons);
      eff_prev = eff;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    chk("joy_out", 12'(joy_out), 12'(exp_out));
    chk("phase", 12'(phase), 12'(mp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int lo, input int hi);
    joy_sel = 1'b0;
    run(lo);
    joy_sel = 1'b1;
    run(hi);
  endtask

  initial begin
    reset = 1'b1; joy_sel = 1'b1; six_btn_en = 1'b0; buttons = 12'h000;
    for (int i = 0; i < 8; i++) hist.push_back(1'b1);
    eff_prev = 1'b1; since = 0; mp = 0; exp_out = 6'h3F;

    run(3);
    chk("reset_out", 12'(joy_out), 12'h03F);
    chk("reset_phase", 12'(phase), 12'h000);

    // Idle with A held: A only appears in the low phase
    reset = 1'b0; buttons = 12'h010;
    run(6);
    chk("idle_a", 12'(joy_out), 12'h03F);

    // Six-button read of X, Y, Z
    six_btn_en = 1'b1; buttons = 12'h380;
    pulse(50, 50);
    pulse(50, 50);
    pulse(50, 10);
    chk("third_rise_p", 12'(phase), 12'd3);
    chk("third_rise_out", 12'(joy_out), 12'h038);
    joy_sel = 1'b0; run(10);
    chk("third_low_out", 12'(joy_out), 12'h030);
    joy_sel = 1'b1; run(10);
    chk("wrap_p", 12'(phase), 12'd0);

    // ID pattern in the third low phase
    buttons = 12'h000;
    pulse(30, 30);
    pulse(30, 30);
    joy_sel = 1'b0; run(10);
    chk("id_low", 12'(joy_out[3:0]), 12'h00F);
    chk("id_phase", 12'(phase), 12'd2);

    // Timeout back to phase 0, then a normal 3-button read
    run(TO + 10);
    chk("timeout_p", 12'(phase), 12'd0);
    buttons = 12'h00F;
    joy_sel = 1'b1; run(10);
    chk("post_to_p", 12'(phase), 12'd1);
    chk("post_to_out", 12'(joy_out), 12'h030);

    // 3-button mode never advances the phase
    six_btn_en = 1'b0; buttons = 12'h00C;
    for (int i = 0; i < 10; i++) pulse(20, 20);
    joy_sel = 1'b0; run(8);
    chk("3btn_low", 12'(joy_out), 12'h03C);
    chk("3btn_phase", 12'(phase), 12'd0);

    // Reset in the middle of a sequence
    joy_sel = 1'b1; six_btn_en = 1'b1; run(10);
    pulse(20, 20);
    pulse(20, 20);
    reset = 1'b1; run(2);
    chk("mid_reset_p", 12'(phase), 12'd0);
    reset = 1'b0; run(5);
    pulse(20, 20);
    chk("rst_then_rise", 12'(phase), 12'd1);

    // Select-to-output latency on a falling edge with Right held
    run(TO + 10);
    buttons = 12'h001;
`ifdef JOY_MD6_SEL_FILTER_EN
    joy_sel = 1'b0; run(2);
    joy_sel = 1'b1; run(10);
    chk("glitch_p", 12'(phase), 12'd0);
    chk("glitch_out", 12'(joy_out), 12'h037);
`endif
    joy_sel = 1'b0; run(LAT - 1);
    chk("lat_hold", 12'(joy_out), 12'h037);
    run(1);
    chk("lat_edge", 12'(joy_out), 12'h03F);
    joy_sel = 1'b1; run(10);
    chk("lat_rise_p", 12'(phase), 12'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)   joy_sel = ~joy_sel;
      if ($urandom_range(0, 15) == 0)  buttons = 12'($urandom);
      if ($urandom_range(0, 199) == 0) six_btn_en = ~six_btn_en;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
